// File: rtl/stream_word_packer.sv
// stream_word_packer
// Gathers N_WORDS consecutive DATA_WIDTH-bit stream words into one wide beat
// of N_WORDS lanes. Word n of a group lands in lane n (lane 0 = LSBs). A word
// carrying S_AXIS_TLAST closes the group early; the unused upper lanes are
// zero-filled and cleared in M_AXIS_TKEEP.
//
// Handshake: a transfer on either side happens on a rising edge where the
// side's TVALID and TREADY are both high. M_AXIS_TVALID, once raised, stays
// high with TDATA/TKEEP/TLAST stable until the downstream takes the beat.
// S_AXIS_TREADY is combinational from M_AXIS_TREADY: a new word is accepted
// whenever the output register is empty or is being emptied on the same edge.
module stream_word_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int N_WORDS    = 4
) (
   input  logic                          clk,
   input  logic                          aresetn,
   input  logic [DATA_WIDTH-1:0]         S_AXIS_TDATA,
   input  logic                          S_AXIS_TVALID,
   input  logic                          S_AXIS_TLAST,
   output logic                          S_AXIS_TREADY,
   output logic [N_WORDS*DATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic [N_WORDS-1:0]            M_AXIS_TKEEP,
   output logic                          M_AXIS_TLAST,
   output logic                          M_AXIS_TVALID,
   input  logic                          M_AXIS_TREADY
);

   localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int BW = N_WORDS * DATA_WIDTH;
   localparam logic [CW-1:0] LAST_LANE = CW'(N_WORDS - 1);

   logic [CW-1:0]      lane_cnt;
   logic [BW-1:0]      acc;
   logic [BW-1:0]      out_data;
   logic [N_WORDS-1:0] out_keep;
   logic               out_last;
   logic               out_valid;

   logic               in_ready;
   logic               in_xfer;
   logic               out_xfer;
   logic               completing;
   logic [BW-1:0]      merged;
   logic [N_WORDS-1:0] lane_mask;

   assign in_ready   = aresetn && (!out_valid || M_AXIS_TREADY);
   assign in_xfer    = S_AXIS_TVALID && in_ready;
   assign out_xfer   = out_valid && M_AXIS_TREADY;
   assign completing = in_xfer && ((lane_cnt == LAST_LANE) || S_AXIS_TLAST);

   assign S_AXIS_TREADY = in_ready;
   assign M_AXIS_TDATA  = out_data;
   assign M_AXIS_TKEEP  = out_keep;
   assign M_AXIS_TLAST  = out_last;
   assign M_AXIS_TVALID = out_valid;

   // Accumulator with the current word placed in its lane; lanes above the
   // current lane are forced to zero so an early flush never leaks old data.
   always_comb begin
      merged    = '0;
      lane_mask = '0;
      for (int k = 0; k < N_WORDS; k++) begin
         if (CW'(k) < lane_cnt) begin
            merged[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
            lane_mask[k] = 1'b1;
         end else if (CW'(k) == lane_cnt) begin
            merged[k*DATA_WIDTH +: DATA_WIDTH] = S_AXIS_TDATA;
            lane_mask[k] = 1'b1;
         end
      end
   end

   // Lane counter and accumulator: advance on each accepted word, restart
   // from lane 0 whenever a group is handed to the output register.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         lane_cnt <= '0;
         acc      <= '0;
      end else if (completing) begin
         lane_cnt <= '0;
         acc      <= '0;
      end else if (in_xfer) begin
         lane_cnt <= lane_cnt + 1'b1;
         acc      <= merged;
      end
   end

   // Output register: loads a finished group (replacing a beat that drains on
   // the same edge), otherwise holds, and drops TVALID once a beat is taken.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else if (completing) begin
         out_data  <= merged;
         out_keep  <= lane_mask;
         out_last  <= S_AXIS_TLAST;
         out_valid <= 1'b1;
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/stream_word_packer.md
Name: stream_word_packer

Overview:
- Gathers N_WORDS consecutive DATA_WIDTH-bit AXI-Stream beats into one N_WORDS*DATA_WIDTH-bit output beat.
- Sits directly upstream of stream_bit_reverse and drives its S_AXIS interface, with N_STREAMS = N_WORDS.
- A narrow ADC/serial word stream becomes the wide lane-parallel bus the reversal stage consumes.
- Supports early flush on TLAST: partial beats are emitted zero-filled, with a lane-valid mask.

Parameters:
- DATA_WIDTH, 32, width of one input word / one output lane
- N_WORDS, 4, input beats per output beat; must be >= 2

Ports:
- clk  in  1  single clock; all logic rising-edge
- aresetn  in  1  asynchronous active-low reset
- S_AXIS_TDATA  in  DATA_WIDTH  input word
- S_AXIS_TVALID  in  1  input word valid
- S_AXIS_TLAST  in  1  last word of packet; forces flush
- S_AXIS_TREADY  out  1  packer can accept a word this cycle
- M_AXIS_TDATA  out  N_WORDS*DATA_WIDTH  packed beat; lane k = bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
- M_AXIS_TKEEP  out  N_WORDS  lane-valid mask, one bit per lane
- M_AXIS_TLAST  out  1  beat closes a packet
- M_AXIS_TVALID  out  1  output beat valid
- M_AXIS_TREADY  in  1  downstream accepts beat

Behaviour:
- Reset (aresetn low, asynchronous): lane counter = 0, accumulator = 0, M_AXIS_TVALID = 0, M_AXIS_TDATA = 0, M_AXIS_TKEEP = 0, M_AXIS_TLAST = 0.
  - Reset mid-packet discards the partial accumulation and any held output beat.
  - After deassertion the next accepted word goes to lane 0.
- Ready rule: S_AXIS_TREADY = aresetn && (!M_AXIS_TVALID || M_AXIS_TREADY).
  - This is a combinational path from M_AXIS_TREADY.
  - No other stall source.
- Transfers:
  - An input transfer is S_AXIS_TVALID && S_AXIS_TREADY.
  - An output transfer is M_AXIS_TVALID && M_AXIS_TREADY.
- Lane placement: the first word of a group lands in lane 0 (LSBs); word n lands in lane n.
- Lane counter: runs 0..N_WORDS-1 and increments on each input transfer.
- Completing transfer: counter == N_WORDS-1, or S_AXIS_TLAST = 1. On the next edge:
  - output register loads the accumulator plus the current word;
  - lanes above the current lane are forced to 0;
  - M_AXIS_TKEEP gets ones in lanes 0..counter, zeros above;
  - M_AXIS_TLAST gets S_AXIS_TLAST;
  - M_AXIS_TVALID goes to 1;
  - counter returns to 0 and the accumulator clears.
- Non-completing transfer: writes the word into the accumulator lane and increments the counter. The output register is untouched.
- Latency: the completing input beat at edge t produces M_AXIS_TVALID = 1 at edge t+1. Throughput is one input word per cycle with no bubbles while the downstream is ready.
- Output hold:
  - While M_AXIS_TVALID && !M_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TKEEP and M_AXIS_TLAST stay stable.
  - No input is accepted during the hold (TREADY low).
- Output drain: an output transfer with no simultaneous completing input clears M_AXIS_TVALID at the next edge.
- Simultaneous output transfer and completing input: the new beat replaces the old one, TVALID stays 1, and no cycle is lost.
- Single-word packet: TLAST on lane 0 emits TKEEP = 0...01 with only lane 0 nonzero.
- TLAST on lane N_WORDS-1: emits full TKEEP with TLAST = 1.
- A counter overflow past N_WORDS-1 is not reachable.
- Input side: S_AXIS_TDATA and S_AXIS_TLAST are ignored when S_AXIS_TVALID = 0.

Test Plan:
- Full groups: reset; DATA_WIDTH=32, N_WORDS=4; stream 0x11111111, 0x22222222, 0x33333333, 0x44444444 with M_AXIS_TREADY=1.
  - Required: one beat, TDATA = 0x44444444_33333333_22222222_11111111, TKEEP = 4'b1111, TLAST = 0.
  - TVALID rises exactly one cycle after the 4th transfer.
- Back-to-back throughput: 8 consecutive words 1..8 with TVALID held high and TREADY=1.
  - Required: S_AXIS_TREADY never drops.
  - Required beats: 0x00000004_00000003_00000002_00000001, then 0x00000008_00000007_00000006_00000005, on consecutive output transfers spaced 4 cycles apart.
- Partial flush: words 0xA, 0xB with TLAST on 0xB.
  - Required: TDATA = 0x00000000_00000000_0000000B_0000000A, TKEEP = 4'b0011, TLAST = 1.
  - The next word lands in lane 0.
- Backpressure: completing a group while M_AXIS_TREADY=0 for 5 cycles.
  - Required: S_AXIS_TREADY=0 for those cycles, and the output beat holds stable.
  - When TREADY returns to 1, the beat transfers and S_AXIS_TREADY returns high the same cycle.
- Simultaneous event: a held beat drains on the same edge a new group completes.
  - Required: TVALID stays 1 and TDATA updates to the new group.
  - Scoreboard: no beat lost or duplicated.
- Mid-operation reset: assert aresetn low asynchronously (between edges) after 2 words of a group.
  - Required: TVALID, TKEEP and TLAST drop immediately, and S_AXIS_TREADY goes 0.
  - After release, 4 new words 5,6,7,8 produce 0x00000008_00000007_00000006_00000005 with no stale lanes.
